// File: rtl/dcache_ctrl_fsm.sv
// Main controller of the 4-way set-associative write-back data cache: address
// decode, hit/miss sequencing (sample, evict, refill, tag write), true-LRU ages.
module dcache_ctrl_fsm #(
  parameter int CACHE_WAY   = 4,
  parameter int ADDR_WIDTH  = 12,
  parameter int TAG_BITS    = 2,
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [ADDR_WIDTH-1:0]    i_addr,
  input  logic                     i_rd,
  input  logic                     i_wr,
  input  logic                     i_hit,
  input  logic [CACHE_WAY-1:0]     i_way_accessed,
  input  logic [TAG_BITS+1:0]      i_LRU_set_tag_info,
  input  logic                     i_readymm,
  input  logic                     i_done_mm,
  output logic [TAG_BITS-1:0]      o_tag,
  output logic [INDEX_BITS-1:0]    o_index,
  output logic [OFFSET_BITS-1:0]   o_offset,
  output logic [1:0]               o_byte_offset,
  output logic                     o_modify,
  output logic                     o_wetag,
  output logic [CACHE_WAY-1:0]     o_LRU,
  output logic                     o_refill_en,
  output logic                     o_sample_data,
  output logic                     o_sample_addr,
  output logic                     o_evict_en,
  output logic [ADDR_WIDTH-5:0]    o_addr_evicted,
  output logic                     o_all_done,
  output logic                     o_stall
);

  localparam int SETS      = 1 << INDEX_BITS;
  localparam int WAY_W     = $clog2(CACHE_WAY);
  localparam int AGE_VEC_W = CACHE_WAY * WAY_W;

  typedef enum logic [2:0] {IDLE, SAMPLE, EVICT, REFILL, DONE} state_t;

  state_t                 state_q, next_state;
  logic [AGE_VEC_W-1:0]   age_q [SETS];
  logic [AGE_VEC_W-1:0]   cur_ages;
  logic                   req;
  logic                   touch_en;
  logic [WAY_W-1:0]       touch_way;
  logic [WAY_W-1:0]       hit_idx;
  logic [WAY_W-1:0]       lru_idx;

  function automatic logic [AGE_VEC_W-1:0] reset_ages();
    logic [AGE_VEC_W-1:0] a;
    a = '0;
    for (int i = 0; i < CACHE_WAY; i++) a[i*WAY_W +: WAY_W] = WAY_W'(i);
    return a;
  endfunction

  // Ages younger than the touched way grow by one; touched way becomes youngest.
  function automatic logic [AGE_VEC_W-1:0] touch(input logic [AGE_VEC_W-1:0] ages,
                                                 input logic [WAY_W-1:0]     w);
    logic [AGE_VEC_W-1:0] nxt;
    logic [WAY_W-1:0]     aw;
    aw  = ages[int'(w)*WAY_W +: WAY_W];
    nxt = ages;
    for (int i = 0; i < CACHE_WAY; i++) begin
      if (i == int'(w))
        nxt[i*WAY_W +: WAY_W] = '0;
      else if (ages[i*WAY_W +: WAY_W] < aw)
        nxt[i*WAY_W +: WAY_W] = ages[i*WAY_W +: WAY_W] + WAY_W'(1);
    end
    return nxt;
  endfunction

  function automatic logic [WAY_W-1:0] onehot_idx(input logic [CACHE_WAY-1:0] oh);
    logic [WAY_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < CACHE_WAY; i++) if (oh[i]) idx = WAY_W'(i);
    return idx;
  endfunction

  assign o_tag          = i_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign o_index        = i_addr[INDEX_BITS+3:4];
  assign o_offset       = i_addr[OFFSET_BITS+1:2];
  assign o_byte_offset  = i_addr[1:0];
  assign o_addr_evicted = {i_LRU_set_tag_info[TAG_BITS-1:0], o_index};

  assign req      = i_rd | i_wr;
  assign cur_ages = age_q[o_index];
  assign hit_idx  = onehot_idx(i_way_accessed);
  assign lru_idx  = onehot_idx(o_LRU);

  always_comb begin
    o_LRU = '0;
    for (int i = 0; i < CACHE_WAY; i++)
      o_LRU[i] = (cur_ages[i*WAY_W +: WAY_W] == WAY_W'(CACHE_WAY-1));
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      for (int s = 0; s < SETS; s++) age_q[s] <= reset_ages();
    end else if (touch_en) begin
      age_q[o_index] <= touch(cur_ages, touch_way);
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) state_q <= IDLE;
    else      state_q <= next_state;
  end

  // Outputs are gated by reset so a reset mid-miss silences the engines at once.
  always_comb begin
    next_state    = state_q;
    o_modify      = 1'b0;
    o_wetag       = 1'b0;
    o_refill_en   = 1'b0;
    o_sample_data = 1'b0;
    o_sample_addr = 1'b0;
    o_evict_en    = 1'b0;
    o_all_done    = 1'b0;
    o_stall       = 1'b0;
    touch_en      = 1'b0;
    touch_way     = hit_idx;
    if (!nrst) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (i_hit) begin
              o_all_done = 1'b1;
              o_modify   = i_wr;
              touch_en   = |i_way_accessed;
            end else begin
              o_stall    = 1'b1;
              next_state = SAMPLE;
            end
          end
        end
        SAMPLE: begin
          o_stall = 1'b1;
          if (i_readymm) begin
            o_sample_addr = 1'b1;
            o_sample_data = 1'b1;
            next_state    = (i_LRU_set_tag_info[TAG_BITS+1:TAG_BITS] == 2'b11) ? EVICT : REFILL;
          end
        end
        EVICT: begin
          o_stall    = 1'b1;
          o_evict_en = 1'b1;
          next_state = REFILL;
        end
        REFILL: begin
          o_stall     = 1'b1;
          o_refill_en = 1'b1;
          if (i_done_mm) begin
            o_wetag    = 1'b1;
            touch_en   = 1'b1;
            touch_way  = lru_idx;
            next_state = DONE;
          end
        end
        DONE: begin
          o_all_done = 1'b1;
          o_modify   = i_wr;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// Bench for dcache_ctrl_fsm: directed hit/miss scenarios with a completion
// scoreboard that pairs every o_all_done pulse with the expected o_modify.
module tb_dcache_ctrl_fsm;

  logic        clk = 1'b0;
  logic        nrst;
  logic [11:0] i_addr;
  logic        i_rd, i_wr, i_hit;
  logic [3:0]  i_way_accessed;
  logic [3:0]  i_LRU_set_tag_info;
  logic        i_readymm, i_done_mm;
  logic [1:0]  o_tag;
  logic [5:0]  o_index;
  logic [1:0]  o_offset, o_byte_offset;
  logic        o_modify, o_wetag;
  logic [3:0]  o_LRU;
  logic        o_refill_en, o_sample_data, o_sample_addr, o_evict_en;
  logic [7:0]  o_addr_evicted;
  logic        o_all_done, o_stall;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  dcache_ctrl_fsm dut (
    .clk(clk), .nrst(nrst), .i_addr(i_addr), .i_rd(i_rd), .i_wr(i_wr),
    .i_hit(i_hit), .i_way_accessed(i_way_accessed),
    .i_LRU_set_tag_info(i_LRU_set_tag_info), .i_readymm(i_readymm),
    .i_done_mm(i_done_mm), .o_tag(o_tag), .o_index(o_index),
    .o_offset(o_offset), .o_byte_offset(o_byte_offset), .o_modify(o_modify),
    .o_wetag(o_wetag), .o_LRU(o_LRU), .o_refill_en(o_refill_en),
    .o_sample_data(o_sample_data), .o_sample_addr(o_sample_addr),
    .o_evict_en(o_evict_en), .o_addr_evicted(o_addr_evicted),
    .o_all_done(o_all_done), .o_stall(o_stall)
  );

  // Scoreboard: every completion pulse consumes one expected o_modify value.
  always @(negedge clk) begin
    if (o_all_done) begin
      logic e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done: all_done=1 with no access outstanding");
      end else begin
        e = exp_q.pop_front();
        if (o_modify !== e) begin
          bad++;
          $display("FAIL sb_modify: got %b want %b", o_modify, e);
        end
      end
    end
  end

  task automatic idle_inputs();
    i_rd = 1'b0; i_wr = 1'b0; i_hit = 1'b0; i_way_accessed = 4'b0000;
    i_readymm = 1'b0; i_done_mm = 1'b0;
  endtask

  task automatic run_miss(input logic [11:0] addr, input logic wr, input logic [3:0] info,
                          input int r_cycles, input int rdy_delay, input bit drop,
                          output int lat, output int n_sample, output int n_evict,
                          output logic [7:0] ev_addr, output logic [3:0] lru_at_sample,
                          output logic [3:0] wetag_way, output logic stall_at_done,
                          output bit early_bad, output bit timed_out);
    int  ref_cnt;
    bit  done;
    lat = 0; n_sample = 0; n_evict = 0; ev_addr = 'x; lru_at_sample = 'x;
    wetag_way = 'x; stall_at_done = 'x; early_bad = 0; ref_cnt = 0; done = 0;
    @(posedge clk); #1;
    idle_inputs();
    i_addr = addr; i_rd = !wr; i_wr = wr; i_LRU_set_tag_info = info;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        i_readymm = (cyc >= 1 + rdy_delay);
        i_done_mm = o_refill_en && (ref_cnt == r_cycles - 1);
        if (drop && o_refill_en) begin i_rd = 1'b0; i_wr = 1'b0; end
      end
      @(negedge clk);
      lat++;
      if (o_sample_addr && o_sample_data) begin n_sample++; lru_at_sample = o_LRU; end
      if (o_evict_en) begin n_evict++; ev_addr = o_addr_evicted; end
      if (o_wetag) wetag_way = o_LRU;
      if (o_refill_en) ref_cnt++;
      if (cyc >= 1 && cyc <= rdy_delay &&
          (o_sample_addr || o_sample_data || o_refill_en || o_evict_en || !o_stall))
        early_bad = 1;
      if (o_all_done) begin stall_at_done = o_stall; done = 1; end
    end
    timed_out = !done;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [7:0] ctl;
    nrst = 1'b1;
    idle_inputs();
    i_addr = 12'h000; i_LRU_set_tag_info = 4'b0000;
    @(posedge clk); #1;
    i_rd = 1'b1; i_hit = 1'b1; i_way_accessed = 4'b0001;
    @(negedge clk);
    ctl = {o_modify, o_wetag, o_refill_en, o_sample_data, o_sample_addr, o_evict_en, o_all_done, o_stall};
    total++;
    if (ctl !== 8'h00) begin bad++; $display("FAIL reset_outputs_in_reset: got %h want 00", ctl); end
    @(posedge clk); #1;
    nrst = 1'b0;
    idle_inputs();
    @(negedge clk);
    ctl = {o_modify, o_wetag, o_refill_en, o_sample_data, o_sample_addr, o_evict_en, o_all_done, o_stall};
    total++;
    if (ctl !== 8'h00) begin bad++; $display("FAIL idle_outputs: got %h want 00", ctl); end
    for (int idx = 0; idx < 64; idx++) begin
      @(posedge clk); #1;
      i_addr = {2'b00, 6'(idx), 4'b0000};
      @(negedge clk);
      total++;
      if (o_LRU !== 4'b1000) begin bad++; $display("FAIL reset_lru idx=%0d: got %b want 1000", idx, o_LRU); end
    end
  endtask

  task automatic test_clean_miss();
    int lat, ns, ne; logic [7:0] ea; logic [3:0] ls, wt; logic sd; bit eb, to;
    @(posedge clk); #1;
    i_addr = 12'h004;
    @(negedge clk);
    total++;
    if ({o_tag, o_index, o_offset, o_byte_offset} !== {2'b00, 6'd0, 2'b01, 2'b00}) begin
      bad++; $display("FAIL decode_004: got %b %b %b %b", o_tag, o_index, o_offset, o_byte_offset);
    end
    exp_q.push_back(1'b0);
    run_miss(12'h004, 1'b0, 4'b0000, 3, 0, 0, lat, ns, ne, ea, ls, wt, sd, eb, to);
    total++; if (to)         begin bad++; $display("FAIL clean_timeout: no all_done within bound"); end
    total++; if (lat != 6)   begin bad++; $display("FAIL clean_latency: got %0d want 6", lat); end
    total++; if (ns != 1)    begin bad++; $display("FAIL clean_sample_cnt: got %0d want 1", ns); end
    total++; if (ne != 0)    begin bad++; $display("FAIL clean_evict_cnt: got %0d want 0", ne); end
    total++; if (wt !== 4'b1000) begin bad++; $display("FAIL clean_wetag_way: got %b want 1000", wt); end
    total++; if (sd !== 1'b0)    begin bad++; $display("FAIL clean_stall_done: got %b want 0", sd); end
    @(negedge clk);
    total++; if (o_LRU !== 4'b0100) begin bad++; $display("FAIL clean_lru_after: got %b want 0100", o_LRU); end
  endtask

  task automatic test_hit();
    @(posedge clk); #1;
    i_addr = 12'h004; i_rd = 1'b1; i_hit = 1'b1; i_way_accessed = 4'b1000;
    exp_q.push_back(1'b0);
    @(negedge clk);
    total++;
    if ({o_all_done, o_stall} !== 2'b10) begin bad++; $display("FAIL read_hit: done,stall=%b%b want 10", o_all_done, o_stall); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    total++; if (o_LRU !== 4'b0100) begin bad++; $display("FAIL hit_lru_after: got %b want 0100", o_LRU); end
  endtask

  task automatic test_write_evict();
    int lat, ns, ne; logic [7:0] ea; logic [3:0] ls, wt; logic sd; bit eb, to;
    @(posedge clk); #1;
    i_addr = 12'h004; i_wr = 1'b1; i_hit = 1'b1; i_way_accessed = 4'b0100;
    exp_q.push_back(1'b1);
    @(negedge clk);
    total++;
    if ({o_all_done, o_modify, o_stall} !== 3'b110) begin
      bad++; $display("FAIL write_hit: done,modify,stall=%b%b%b want 110", o_all_done, o_modify, o_stall);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    total++; if (o_LRU !== 4'b0010) begin bad++; $display("FAIL write_hit_lru: got %b want 0010", o_LRU); end
    exp_q.push_back(1'b1);
    run_miss(12'hC08, 1'b1, 4'b1101, 3, 0, 0, lat, ns, ne, ea, ls, wt, sd, eb, to);
    total++; if (to)         begin bad++; $display("FAIL dirty_timeout: no all_done within bound"); end
    total++; if (lat != 7)   begin bad++; $display("FAIL dirty_latency: got %0d want 7", lat); end
    total++; if (ne != 1)    begin bad++; $display("FAIL dirty_evict_cnt: got %0d want 1", ne); end
    total++; if (ea !== 8'h40) begin bad++; $display("FAIL dirty_evict_addr: got %h want 40", ea); end
    total++; if (ls !== 4'b0010 || wt !== 4'b0010) begin
      bad++; $display("FAIL dirty_lru_stable: sample=%b wetag=%b want 0010", ls, wt);
    end
    @(negedge clk);
    total++; if (o_LRU !== 4'b0001) begin bad++; $display("FAIL dirty_lru_after: got %b want 0001", o_LRU); end
  endtask

  task automatic test_ready_wait();
    int lat, ns, ne; logic [7:0] ea; logic [3:0] ls, wt; logic sd; bit eb, to;
    exp_q.push_back(1'b0);
    run_miss(12'h010, 1'b0, 4'b1000, 3, 5, 0, lat, ns, ne, ea, ls, wt, sd, eb, to);
    total++; if (to)        begin bad++; $display("FAIL wait_timeout: no all_done within bound"); end
    total++; if (eb)        begin bad++; $display("FAIL wait_early_activity: activity or stall low while readymm=0"); end
    total++; if (lat != 11) begin bad++; $display("FAIL wait_latency: got %0d want 11", lat); end
    total++; if (ns != 1 || wt !== 4'b1000) begin
      bad++; $display("FAIL wait_sample_wetag: samples=%0d wetag=%b want 1 1000", ns, wt);
    end
  endtask

  task automatic test_drop();
    int lat, ns, ne; logic [7:0] ea; logic [3:0] ls, wt; logic sd; bit eb, to;
    exp_q.push_back(1'b0);
    run_miss(12'h040, 1'b0, 4'b0000, 2, 0, 1, lat, ns, ne, ea, ls, wt, sd, eb, to);
    total++; if (to)       begin bad++; $display("FAIL drop_timeout: no all_done after dropped request"); end
    total++; if (lat != 5) begin bad++; $display("FAIL drop_latency: got %0d want 5", lat); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    i_addr = 12'h020; i_rd = 1'b1; i_hit = 1'b1; i_way_accessed = 4'b1000;
    exp_q.push_back(1'b0);
    @(negedge clk);
    total++; if (o_all_done !== 1'b1) begin bad++; $display("FAIL b2b_first: done=%b want 1", o_all_done); end
    @(posedge clk); #1;
    i_wr = 1'b1; i_way_accessed = 4'b0100;
    exp_q.push_back(1'b1);
    @(negedge clk);
    total++; if ({o_all_done, o_modify} !== 2'b11) begin
      bad++; $display("FAIL b2b_second_rdwr: done,modify=%b%b want 11", o_all_done, o_modify);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    total++; if (o_LRU !== 4'b0010) begin bad++; $display("FAIL b2b_lru: got %b want 0010", o_LRU); end
  endtask

  task automatic test_reset_mid_refill();
    bit seen = 0;
    @(posedge clk); #1;
    idle_inputs();
    i_addr = 12'h030; i_rd = 1'b1; i_LRU_set_tag_info = 4'b0000; i_readymm = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (o_refill_en) seen = 1;
      else begin @(posedge clk); #1; end
    end
    total++; if (!seen) begin bad++; $display("FAIL rst_mid_no_refill: refill_en never rose"); end
    @(posedge clk); #1;
    nrst = 1'b1; i_rd = 1'b0;
    @(negedge clk);
    total++; if ({o_refill_en, o_stall} !== 2'b00) begin
      bad++; $display("FAIL rst_mid_immediate: refill,stall=%b%b want 00", o_refill_en, o_stall);
    end
    @(posedge clk); #1;
    nrst = 1'b0; idle_inputs();
    @(negedge clk);
    total++; if ({o_refill_en, o_stall, o_all_done} !== 3'b000) begin
      bad++; $display("FAIL rst_mid_idle: refill,stall,done=%b%b%b want 000", o_refill_en, o_stall, o_all_done);
    end
    @(posedge clk); #1;
    i_addr = 12'h004;
    @(negedge clk);
    total++; if (o_LRU !== 4'b1000) begin bad++; $display("FAIL rst_mid_lru_set0: got %b want 1000", o_LRU); end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_hit();
    test_write_evict();
    test_ready_wait();
    test_drop();
    test_back_to_back();
    test_reset_mid_refill();
    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: %0d completions missing", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
